// File: rtl/seg_result_display.sv
// Captures the add/sub unit's result on a load strobe and scans it onto a 4-digit 7-segment panel.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the tens digit for values below 10.
module seg_result_display #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en_in,
    input  logic       op_sel,
    input  logic [3:0] result,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CNT_W   = 20;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 32'd1);

    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_S     = 7'h6D;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       cap_res_q, cap_res_d;
    logic             cap_op_q, cap_op_d;
    logic             cap_en_q, cap_en_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic [3:0]       ones_s;
    logic             tens_s;
    logic [6:0]       glyph_s;

    // Scan divider and digit index
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end
    end

    // Capture registers follow the unit's outputs while load is high
    always_comb begin
        cap_res_d = cap_res_q;
        cap_op_d  = cap_op_q;
        cap_en_d  = cap_en_q;
        if (load) begin
            cap_res_d = result;
            cap_op_d  = op_sel;
            cap_en_d  = en_in;
        end else begin
            cap_res_d = cap_res_q;
            cap_op_d  = cap_op_q;
            cap_en_d  = cap_en_q;
        end
    end

    // Decimal split of the captured 0..15 value
    always_comb begin
        tens_s = 1'b0;
        ones_s = cap_res_q;
        if (cap_res_q >= 4'd10) begin
            tens_s = 1'b1;
            ones_s = 4'(cap_res_q - 4'd10);
        end else begin
            tens_s = 1'b0;
            ones_s = cap_res_q;
        end
    end

    // Glyph for the currently scanned digit, then polarity correction
    always_comb begin
        glyph_s = GLYPH_BLANK;
        if (!cap_en_q) begin
            glyph_s = GLYPH_DASH;
        end else begin
            case (idx_q)
                2'd0: glyph_s = digit_seg(ones_s);
                2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                    glyph_s = tens_s ? digit_seg(4'd1) : GLYPH_BLANK;
`else
                    glyph_s = tens_s ? digit_seg(4'd1) : digit_seg(4'd0);
`endif
                end
                2'd2:    glyph_s = GLYPH_BLANK;
                2'd3:    glyph_s = cap_op_q ? GLYPH_S : GLYPH_A;
                default: glyph_s = GLYPH_BLANK;
            endcase
        end
        seg_d = SEG_ACTIVE_LOW ? ~{1'b0, glyph_s} : {1'b0, glyph_s};
        an_d  = AN_ACTIVE_LOW ? ~(4'b0001 << idx_q) : (4'b0001 << idx_q);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            idx_q     <= 2'd0;
            cap_res_q <= 4'd0;
            cap_op_q  <= 1'b0;
            cap_en_q  <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cap_res_q <= cap_res_d;
            cap_op_q  <= cap_op_d;
            cap_en_q  <= cap_en_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
